// File: rtl/audio_codec_cfg_seq_if.sv
// audio_codec_cfg_seq_if: control, command-table and codec pin bundle for the config sequencer
interface audio_codec_cfg_seq_if #(
  parameter int AW = 6
);
  logic          start;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic          codec_rst_n;
  logic          spi_cs_n;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          busy;
  logic          done;
  logic          err;
  modport master (
    input  start, tbl_data,
    output tbl_addr, codec_rst_n, spi_cs_n, spi_sclk, spi_mosi, busy, done, err
  );
  modport slave (
    output start, tbl_data,
    input  tbl_addr, codec_rst_n, spi_cs_n, spi_sclk, spi_mosi, busy, done, err
  );
endinterface

// File: rtl/audio_codec_cfg_seq.sv
// audio_codec_cfg_seq: codec reset/power-up sequencer that replays a command table as SPI writes and delays
module audio_codec_cfg_seq #(
  parameter int CLK_DIV    = 8,
  parameter int RST_LOW    = 1000,
  parameter int PWRUP_WAIT = 50000,
  parameter int DELAY_UNIT = 50000,
  parameter int TBL_LEN    = 64
) (
  input logic                   CLK_50MHZ,
  input logic                   RST,
  audio_codec_cfg_seq_if.master bus
);
  localparam int AW   = $clog2(TBL_LEN);
  localparam int DMAX = 255 * DELAY_UNIT;
  localparam int M1   = RST_LOW > PWRUP_WAIT ? RST_LOW : PWRUP_WAIT;
  localparam int M2   = DMAX > M1 ? DMAX : M1;
  localparam int M3   = 2 * CLK_DIV > M2 ? 2 * CLK_DIV : M2;
  localparam int CW   = $clog2(M3 + 1);
  typedef enum logic [3:0] {
    IDLE, RSTLO, PWRUP, FETCH, DECODE, CSSET, SHIFT, CSHOLD, GAP, DELAY, DONE
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, tgt_q, tgt_d, lim;
  logic [15:0]   sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [AW-1:0] tbl_addr_q, tbl_addr_d;
  logic          codec_rst_n_q, codec_rst_n_d, cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          last, adv;
  assign lim  = state_q == RSTLO ? CW'(RST_LOW) :
                state_q == PWRUP ? CW'(PWRUP_WAIT) :
                state_q == DELAY ? tgt_q :
                (state_q == SHIFT || state_q == GAP) ? CW'(2 * CLK_DIV) : CW'(CLK_DIV);
  assign last = cnt_q == lim - CW'(1);
  // next-state and registered-output decode; every timed state restarts cnt at its last cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = last ? '0 : cnt_q + CW'(1);
    tgt_d         = tgt_q;
    sh_d          = sh_q;
    bit_d         = bit_q;
    tbl_addr_d    = tbl_addr_q;
    codec_rst_n_d = codec_rst_n_q;
    cs_n_d        = cs_n_q;
    sclk_d        = sclk_q;
    mosi_d        = mosi_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    adv           = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d       = RSTLO;
          tbl_addr_d    = '0;
          codec_rst_n_d = 1'b0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          err_d         = 1'b0;
        end
      end
      RSTLO: if (last) begin
        state_d       = PWRUP;
        codec_rst_n_d = 1'b1;
      end
      PWRUP: state_d = last ? FETCH : PWRUP;
      FETCH: begin
        cnt_d   = '0;
        state_d = DECODE;
      end
      DECODE: begin
        cnt_d = '0;
        if (bus.tbl_data == 16'hFFFF) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (bus.tbl_data[15]) begin
          tgt_d   = CW'(bus.tbl_data[7:0]) * CW'(DELAY_UNIT);
          adv     = bus.tbl_data[7:0] == 8'd0;
          state_d = DELAY;
        end else begin
          state_d = CSSET;
          cs_n_d  = 1'b0;
          sh_d    = {bus.tbl_data[14:8], 1'b0, bus.tbl_data[7:0]};
        end
      end
      CSSET: if (last) begin
        state_d = SHIFT;
        sclk_d  = 1'b1;
        mosi_d  = sh_q[15];
        sh_d    = {sh_q[14:0], 1'b0};
        bit_d   = '0;
      end
      SHIFT: begin
        sclk_d = cnt_q == CW'(CLK_DIV - 1) ? 1'b0 : sclk_q;
        if (last && bit_q == 4'd15) begin
          state_d = CSHOLD;
          mosi_d  = 1'b0;
        end else if (last) begin
          bit_d  = bit_q + 4'd1;
          sclk_d = 1'b1;
          mosi_d = sh_q[15];
          sh_d   = {sh_q[14:0], 1'b0};
        end
      end
      CSHOLD: if (last) begin
        state_d = GAP;
        cs_n_d  = 1'b1;
      end
      GAP:   adv = last;
      DELAY: adv = last;
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (adv && tbl_addr_q == AW'(TBL_LEN - 1)) begin
      state_d = DONE;
      err_d   = 1'b1;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end else if (adv) begin
      state_d    = FETCH;
      tbl_addr_d = tbl_addr_q + AW'(1);
    end
  end
  // state and output registers; reset drops every pin to its idle value on the next edge
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tgt_q         <= '0;
      sh_q          <= '0;
      bit_q         <= '0;
      tbl_addr_q    <= '0;
      codec_rst_n_q <= 1'b0;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b0;
      mosi_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      sh_q          <= sh_d;
      bit_q         <= bit_d;
      tbl_addr_q    <= tbl_addr_d;
      codec_rst_n_q <= codec_rst_n_d;
      cs_n_q        <= cs_n_d;
      sclk_q        <= sclk_d;
      mosi_q        <= mosi_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end
  assign bus.tbl_addr    = tbl_addr_q;
  assign bus.codec_rst_n = codec_rst_n_q;
  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_sclk    = sclk_q;
  assign bus.spi_mosi    = mosi_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_audio_codec_cfg_seq.sv
// tb_audio_codec_cfg_seq: random and directed command tables checked against a cycle-cost model
module tb_audio_codec_cfg_seq;
  localparam int CLK_DIV = 2, RST_LOW = 4, PWRUP_WAIT = 10, DELAY_UNIT = 3, TBL_LEN = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rom [TBL_LEN];
  int n_chk = 0, n_pass = 0;
  int rel = 0, busy_n = 0, rstlo_n = 0, rises = 0, nb = 0;
  int chg_q[$], nb_q[$], exp_chg[$];
  logic [15:0] fr_q[$], exp_fr[$];
  logic [15:0] cur = '0;
  logic pbusy = 1'b0, pcs = 1'b1, psclk = 1'b0;
  logic [1:0] paddr = '0;
  int exp_busy, exp_err, exp_addr;
  audio_codec_cfg_seq_if #(.AW(2)) bus ();
  audio_codec_cfg_seq #(
    .CLK_DIV(CLK_DIV), .RST_LOW(RST_LOW), .PWRUP_WAIT(PWRUP_WAIT),
    .DELAY_UNIT(DELAY_UNIT), .TBL_LEN(TBL_LEN)
  ) dut (
    .CLK_50MHZ(clk),
    .RST(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // synchronous command ROM
  always @(posedge clk) bus.tbl_data <= rom[bus.tbl_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // pin monitor: busy timing, reset-pin low time, address steps and SPI frames sampled on SCLK falls
  initial forever begin
    @(negedge clk);
    if (bus.busy) begin
      rel = pbusy ? rel + 1 : 0;
      busy_n++;
      if (!bus.codec_rst_n) rstlo_n++;
      if (pbusy && bus.tbl_addr != paddr) chg_q.push_back(rel);
    end
    if (pcs && !bus.spi_cs_n) begin cur = '0; nb = 0; end
    if (!bus.spi_cs_n && psclk && !bus.spi_sclk) begin cur = {cur[14:0], bus.spi_mosi}; nb++; end
    if (!bus.spi_cs_n && !psclk && bus.spi_sclk) rises++;
    if (!pcs && bus.spi_cs_n) begin fr_q.push_back(cur); nb_q.push_back(nb); end
    pbusy = bus.busy; pcs = bus.spi_cs_n; psclk = bus.spi_sclk; paddr = bus.tbl_addr;
  end
  task automatic model();
    int t;
    logic [15:0] w;
    exp_fr.delete(); exp_chg.delete();
    t = RST_LOW + PWRUP_WAIT;
    exp_err = 1; exp_addr = TBL_LEN - 1;
    for (int k = 0; k < TBL_LEN; k++) begin
      w = rom[k];
      t += 2;
      if (w == 16'hFFFF) begin exp_err = 0; exp_addr = k; break; end
      if (w[15]) t += int'(w[7:0]) * DELAY_UNIT;
      else begin exp_fr.push_back({w[14:8], 1'b0, w[7:0]}); t += 36 * CLK_DIV; end
      if (k < TBL_LEN - 1) exp_chg.push_back(t);
    end
    exp_busy = t;
  endtask
  task automatic run_case(input string tag, input bit poke);
    int i;
    model();
    fr_q.delete(); nb_q.delete(); chg_q.delete(); busy_n = 0; rstlo_n = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk({tag, ".busy_up"}, bus.busy, 1);
    chk({tag, ".done_clr"}, bus.done, 0);
    chk({tag, ".err_clr"}, bus.err, 0);
    if (poke) begin
      repeat ($urandom_range(20, 120)) @(negedge clk);
      if (bus.busy) begin
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
      end
    end
    for (i = 0; i < 5000 && !bus.done; i++) @(negedge clk);
    @(negedge clk);
    chk({tag, ".done"}, bus.done, 1);
    chk({tag, ".busy_dn"}, bus.busy, 0);
    chk({tag, ".err"}, bus.err, exp_err);
    chk({tag, ".addr"}, bus.tbl_addr, exp_addr);
    chk({tag, ".busy_len"}, busy_n, exp_busy);
    chk({tag, ".rst_low"}, rstlo_n, RST_LOW);
    chk({tag, ".idle_pins"}, {bus.codec_rst_n, bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi}, 4'b1100);
    chk({tag, ".nframes"}, fr_q.size(), exp_fr.size());
    for (int k = 0; k < fr_q.size() && k < exp_fr.size(); k++) begin
      chk($sformatf("%s.frame%0d", tag, k), fr_q[k], exp_fr[k]);
      chk($sformatf("%s.bits%0d", tag, k), nb_q[k], 16);
    end
    chk({tag, ".nsteps"}, chg_q.size(), exp_chg.size());
    for (int k = 0; k < chg_q.size() && k < exp_chg.size(); k++)
      chk($sformatf("%s.step%0d", tag, k), chg_q[k], exp_chg[k]);
  endtask
  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask
  initial begin
    int i, r;
    bus.start = 1'b1;
    load(16'h0101, 16'hFFFF, 16'h0000, 16'h0000);
    repeat (5) @(negedge clk);
    chk("rst.pins", {bus.codec_rst_n, bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi}, 4'b0100);
    chk("rst.flags", {bus.busy, bus.done, bus.err}, 3'b000);
    chk("rst.addr", bus.tbl_addr, 0);
    rst = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.no_start", bus.busy, 0);
    run_case("write", 0);
    load(16'h8005, 16'h3F80, 16'hFFFF, 16'h0000);
    run_case("delay", 0);
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_case("nomark", 0);
    load(16'h0101, 16'hFFFF, 16'h0000, 16'h0000);
    run_case("poke1", 1);
    run_case("poke2", 1);
    rises = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (i = 0; i < 2000 && rises < 7; i++) @(negedge clk);
    chk("midrst.cs_low", bus.spi_cs_n, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.pins", {bus.codec_rst_n, bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi}, 4'b0100);
    chk("midrst.flags", {bus.busy, bus.done, bus.err}, 3'b000);
    chk("midrst.addr", bus.tbl_addr, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    run_case("rerun", 0);
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < TBL_LEN; k++) begin
        r = $urandom_range(0, 9);
        rom[k] = r < 6 ? {1'b0, 15'($urandom)} :
                 r < 8 ? {1'b1, 7'($urandom), 8'($urandom_range(0, 6))} : 16'hFFFF;
      end
      run_case($sformatf("rand%0d", n), 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
